// File: rtl/seq_shifter_right.sv
`default_nettype none
// ============================================================================
// Module   : seq_shifter_right
// Purpose  : Iterative logical/arithmetic right shifter. Accepts an operand and
//            a shift amount over a valid/ready handshake, shifts one bit per
//            clock, and holds the result on a valid/ready output port until
//            the consumer takes it. Only one operation is in flight at a time.
// Ports    : clk       - rising-edge clock
//            rst_n     - asynchronous active-low reset
//            in_valid  - operand presented
//            in_ready  - block can accept an operand (high only when idle)
//            in_data   - operand [WIDTH]
//            in_shamt  - unsigned right-shift amount [SHAMT_W]
//            in_arith  - 1 = sign-fill, 0 = zero-fill
//            out_valid - result available
//            out_ready - consumer accepts result
//            out_data  - shifted result [WIDTH]
// Revision : 1.0 - initial release
// ============================================================================
module seq_shifter_right #(
  parameter int WIDTH   = 4,
  parameter int SHAMT_W = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic               in_arith,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sreg_q,  sreg_d;
  logic [SHAMT_W-1:0] cnt_q,   cnt_d;
  logic               arith_q, arith_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      arith_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      arith_q <= arith_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    cnt_d     = cnt_q;
    arith_d   = arith_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          sreg_d  = in_data;
          cnt_d   = in_shamt;
          arith_d = in_arith;
          state_d = (in_shamt != '0) ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        // The fill bit is the current MSB in arithmetic mode, so repeated
        // shifts past WIDTH saturate to all sign bits (or all zeros).
        sreg_d = {arith_q & sreg_q[WIDTH-1], sreg_q[WIDTH-1:1]};
        cnt_d  = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // The shift register is left untouched after the output handshake, so the
  // result stays on out_data in IDLE until the next operand is captured.
  assign out_data = sreg_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_shifter_right.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_shifter_right
// Purpose  : Self-checking bench for seq_shifter_right (WIDTH=4, SHAMT_W=2).
//            Expected result and latency are queued when an operand is
//            accepted and compared when the result appears.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_shifter_right;

  localparam int WIDTH   = 4;
  localparam int SHAMT_W = 2;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SHAMT_W-1:0] in_shamt;
  logic               in_arith;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;

  seq_shifter_right #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_arith  (in_arith),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Scoreboard entry: {expected latency, expected data}
  logic [7:0] sb_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs === expv) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  // Drive one operand, push its expected result, wait for the result while
  // scribbling on the inputs, compare, optionally stall the consumer, then
  // complete the output handshake.
  task automatic run_op(input string tag, input logic [WIDTH-1:0] d,
                        input logic [SHAMT_W-1:0] s, input logic a, input int hold);
    logic [WIDTH-1:0] exp_d;
    logic [7:0]       ent;
    int               lat;
    int               waited;
    bit               seen;

    if (a) exp_d = WIDTH'($signed(d) >>> s);
    else   exp_d = d >> s;

    @(negedge clk);
    waited = 0;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_rdy"}, 32'(in_ready), 32'd1);

    in_valid  = 1'b1;
    in_data   = d;
    in_shamt  = s;
    in_arith  = a;
    out_ready = 1'b0;
    sb_q.push_back({4'(s + 1), 4'(exp_d)});
    @(posedge clk);

    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      // Later input changes and pulses must not disturb the operation.
      in_valid = lat[0];
      in_data  = ~d;
      in_shamt = ~s;
      in_arith = ~a;
      if (out_valid) seen = 1'b1;
    end
    check({tag, "_seen"}, 32'(seen), 32'd1);

    ent = sb_q.pop_front();
    check({tag, "_data"}, 32'(out_data), 32'(ent[3:0]));
    check({tag, "_lat"},  32'(lat),      32'(ent[7:4]));

    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      in_data  = in_data + 4'd3;
      check({tag, "_hold_v"},   32'(out_valid), 32'd1);
      check({tag, "_hold_d"},   32'(out_data),  32'(ent[3:0]));
      check({tag, "_hold_rdy"}, 32'(in_ready),  32'd0);
    end

    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_post_rdy"}, 32'(in_ready),  32'd1);
    check({tag, "_post_v"},   32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [WIDTH-1:0]   rd;
    logic [SHAMT_W-1:0] rs;
    logic               ra;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_arith  = 1'b0;
    out_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_rdy",  32'(in_ready),  32'd1);
    check("rst_v",    32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data),  32'd0);
    rst_n = 1'b1;

    // Directed cases from the test list, with fixed expectations.
    run_op("t1_log2",   4'b1011, 2'd2, 1'b0, 0);
    check("t1_const", 32'(out_data), 32'(4'b0010));
    run_op("t2_ari2",   4'b1011, 2'd2, 1'b1, 0);
    check("t2_const", 32'(out_data), 32'(4'b1110));
    run_op("t3_zero",   4'b0110, 2'd0, 1'b0, 0);
    check("t3_const", 32'(out_data), 32'(4'b0110));
    run_op("t4_ari3",   4'b1000, 2'd3, 1'b1, 0);
    check("t4a_const", 32'(out_data), 32'(4'b1111));
    run_op("t4_log3",   4'b1000, 2'd3, 1'b0, 0);
    check("t4b_const", 32'(out_data), 32'(4'b0001));
    // Consumer stall with in_valid pulsing; result must hold, no capture.
    run_op("t5_stall",  4'b1101, 2'd1, 1'b1, 5);
    check("t5_const", 32'(out_data), 32'(4'b1110));
    check("t5_sb_empty", 32'(sb_q.size()), 32'd0);

    // Reset in the middle of a 3-bit shift.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 4'b1001;
    in_shamt = 2'd3;
    in_arith = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("t6_busy", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("t6_rst_v",    32'(out_valid), 32'd0);
    check("t6_rst_data", 32'(out_data),  32'd0);
    check("t6_rst_rdy",  32'(in_ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("t6_no_out", 32'(out_valid), 32'd0);
    end
    run_op("t6_fresh", 4'b1011, 2'd1, 1'b0, 0);
    check("t6_const", 32'(out_data), 32'(4'b0101));

    // Random operands with random consumer stalls.
    for (int k = 0; k < 24; k++) begin
      rd = WIDTH'($urandom);
      rs = SHAMT_W'($urandom);
      ra = 1'($urandom);
      run_op("rnd", rd, rs, ra, int'($urandom_range(0, 2)));
    end

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
